nios_debug_ocimem_ctrl: RTL and testbench

//  System-clock consumer of the debug-slave sysclk stage: decodes jdo plus the

---
 rtl/nios_debug_ocimem_ctrl.sv | 175 +++++++++++++++++
 tb/tb_nios_debug_ocimem_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_debug_ocimem_ctrl.sv
// Debug RAM controller: serves JTAG monitor reads/writes from the debug slave
// and arbitrates CPU Avalon-MM access to the same RAM (JTAG has priority).
module nios_debug_ocimem_ctrl #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, J_RD, C_RD} state_e;
  typedef enum logic [1:0] {OP_WR_INC, OP_RD_NOINC, OP_RD_INC} op_e;

  state_e            state_q, state_d;
  op_e               pend_op_q, pend_op_d;
  logic              pend_valid_q, pend_valid_d;
  logic              rd_inc_q, rd_inc_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic              ready_q, ready_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       jrd_q;

  logic [31:0]       mem_q [DEPTH];
  logic              wr_en_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [31:0]       wr_data_c;
  logic [3:0]        wr_be_c;
  logic              jrd_en_c;
  logic              wait_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [31:0]       rd_word_c;

  // jdo bits outside the address/data fields carry nothing for this block
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // single read port: a pending JTAG op owns the address, otherwise the CPU
  assign rd_addr_c = pend_valid_q ? mon_a_q : cpu_address;
  assign rd_word_c = mem_q[rd_addr_c];

  assign cpu_readdata    = cpu_rdata_q;
  assign cpu_waitrequest = wait_c;
  assign MonDReg         = mon_d_q;
  assign MonAReg         = mon_a_q;
  assign monitor_ready   = ready_q;

  // debug RAM write port with byte lanes; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_c[b]) mem_q[wr_addr_c][8*b +: 8] <= wr_data_c[8*b +: 8];
      end
    end
  end

  // state and control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
      pend_op_q    <= OP_WR_INC;
      rd_inc_q     <= 1'b0;
      mon_a_q      <= '0;
      mon_d_q      <= '0;
      ready_q      <= 1'b0;
      cpu_rdata_q  <= '0;
      jrd_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_op_q    <= pend_op_d;
      rd_inc_q     <= rd_inc_d;
      mon_a_q      <= mon_a_d;
      mon_d_q      <= mon_d_d;
      ready_q      <= ready_d;
      cpu_rdata_q  <= cpu_rdata_d;
      if (jrd_en_c) jrd_q <= rd_word_c;
    end
  end

  // arbitration FSM; pulse capture comes last so a new pulse wins any collision
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_op_d    = pend_op_q;
    rd_inc_d     = rd_inc_q;
    mon_a_d      = mon_a_q;
    mon_d_d      = mon_d_q;
    ready_d      = ready_q;
    cpu_rdata_d  = cpu_rdata_q;
    wr_en_c      = 1'b0;
    wr_addr_c    = mon_a_q;
    wr_data_c    = mon_d_q;
    wr_be_c      = 4'hF;
    jrd_en_c     = 1'b0;
    wait_c       = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          pend_valid_d = 1'b0;
          if (pend_op_q == OP_WR_INC) begin
            wr_en_c = 1'b1;
            mon_a_d = mon_a_q + ADDR_W'(1);
          end else begin
            jrd_en_c = 1'b1;
            rd_inc_d = (pend_op_q == OP_RD_INC);
            state_d  = J_RD;
          end
        end else if (cpu_write) begin
          wr_en_c   = 1'b1;
          wr_addr_c = cpu_address;
          wr_data_c = cpu_writedata;
          wr_be_c   = cpu_byteenable;
          wait_c    = 1'b0;
        end else if (cpu_read) begin
          cpu_rdata_d = rd_word_c;
          state_d     = C_RD;
        end
      end
      J_RD: begin
        mon_d_d = jrd_q;
        ready_d = 1'b1;
        if (rd_inc_q) mon_a_d = mon_a_q + ADDR_W'(1);
        state_d = IDLE;
      end
      C_RD: begin
        wait_c  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (take_action_ocimem_a) begin
      mon_a_d = jdo[17 +: ADDR_W];
      ready_d = 1'b0;
      if (jdo[34]) begin
        pend_valid_d = 1'b1;
        pend_op_d    = OP_RD_NOINC;
      end
    end
    if (take_action_ocimem_b) begin
      mon_d_d      = jdo[34:3];
      pend_valid_d = 1'b1;
      pend_op_d    = OP_WR_INC;
    end
    if (take_no_action_ocimem_a) begin
      pend_valid_d = 1'b1;
      pend_op_d    = OP_RD_INC;
      ready_d      = 1'b0;
    end

    if (reset) begin
      wr_en_c = 1'b0;
      wait_c  = 1'b1;
    end
  end

endmodule

// File: tb/tb_nios_debug_ocimem_ctrl.sv
// Bench for nios_debug_ocimem_ctrl: architectural model plus directed scenarios.
module tb_nios_debug_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [7:0]  cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;
  logic        monitor_ready;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  nios_debug_ocimem_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
    .MonDReg(MonDReg), .MonAReg(MonAReg), .monitor_ready(monitor_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Architectural state plus "what the RAM is busy with": a JTAG read whose
  // result is in flight, or a CPU read being returned.
  logic [31:0] m_mem [256];
  logic [7:0]  m_a = '0;
  logic [31:0] m_d = '0;
  logic        m_rdy = 1'b0;
  logic        m_pv = 1'b0;
  int          m_pop = 0;          // 0 write+inc, 1 read, 2 read+inc
  logic [31:0] m_crdata = '0;
  bit          m_jbusy = 1'b0, m_jinc = 1'b0, m_cbusy = 1'b0;
  logic [31:0] m_jval = '0;

  always @(posedge clk) begin
    logic [7:0]  n_a;
    logic [31:0] n_d;
    logic        n_rdy, n_pv;
    int          n_pop;
    if (reset) begin
      m_a = '0; m_d = '0; m_rdy = 1'b0; m_pv = 1'b0; m_pop = 0;
      m_crdata = '0; m_jbusy = 1'b0; m_cbusy = 1'b0;
    end else begin
      n_a = m_a; n_d = m_d; n_rdy = m_rdy; n_pv = m_pv; n_pop = m_pop;
      if (m_jbusy) begin
        n_d = m_jval; n_rdy = 1'b1;
        if (m_jinc) n_a = m_a + 8'd1;
        m_jbusy = 1'b0;
      end else if (m_cbusy) begin
        m_cbusy = 1'b0;
      end else if (m_pv) begin
        n_pv = 1'b0;
        if (m_pop == 0) begin
          m_mem[m_a] = m_d;
          n_a = m_a + 8'd1;
        end else begin
          m_jval = m_mem[m_a]; m_jinc = (m_pop == 2); m_jbusy = 1'b1;
        end
      end else if (cpu_write) begin
        for (int b = 0; b < 4; b++)
          if (cpu_byteenable[b]) m_mem[cpu_address][8*b +: 8] = cpu_writedata[8*b +: 8];
      end else if (cpu_read) begin
        m_crdata = m_mem[cpu_address]; m_cbusy = 1'b1;
      end
      if (take_action_ocimem_a) begin
        n_a = jdo[24:17]; n_rdy = 1'b0;
        if (jdo[34]) begin n_pv = 1'b1; n_pop = 1; end
      end
      if (take_action_ocimem_b) begin n_d = jdo[34:3]; n_pv = 1'b1; n_pop = 0; end
      if (take_no_action_ocimem_a) begin n_pv = 1'b1; n_pop = 2; n_rdy = 1'b0; end
      m_a = n_a; m_d = n_d; m_rdy = n_rdy; m_pv = n_pv; m_pop = n_pop;
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    logic exp_wait;
    if (chk_en) begin
      if (reset) exp_wait = 1'b1;
      else if (m_cbusy) exp_wait = 1'b0;
      else if (!m_jbusy && !m_pv && cpu_write) exp_wait = 1'b0;
      else exp_wait = 1'b1;
      chk("MonDReg", MonDReg, m_d);
      chk("MonAReg", {24'd0, MonAReg}, {24'd0, m_a});
      chk("monitor_ready", {31'd0, monitor_ready}, {31'd0, m_rdy});
      chk("cpu_waitrequest", {31'd0, cpu_waitrequest}, {31'd0, exp_wait});
      chk("cpu_readdata", cpu_readdata, m_crdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input logic [7:0] addr, input logic rd);
    jdo = '0; jdo[24:17] = addr; jdo[34] = rd;
    take_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic pulse_b(input logic [31:0] data);
    jdo = '0; jdo[34:3] = data;
    take_action_ocimem_b = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic pulse_n();
    take_no_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_no_action_ocimem_a = 1'b0;
  endtask

  // hold the request until waitrequest drops; leave cpu_read up on entry if already set
  task automatic cpu_rd(input logic [7:0] addr, output logic [31:0] data);
    bit done = 1'b0;
    cpu_address = addr; cpu_read = 1'b1; data = 'x;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (!cpu_waitrequest) begin data = cpu_readdata; done = 1'b1; end
      @(posedge clk); #1;
    end
    cpu_read = 1'b0;
    if (!done) chk("cpu_rd_timeout", 32'd1, 32'd0);
  endtask

  task automatic cpu_wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
    bit done = 1'b0;
    cpu_address = addr; cpu_writedata = data; cpu_byteenable = be; cpu_write = 1'b1;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (!cpu_waitrequest) done = 1'b1;
      @(posedge clk); #1;
    end
    cpu_write = 1'b0;
    if (!done) chk("cpu_wr_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0] rd;
    reset = 1'b1; jdo = '0;
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
    cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_writedata = '0; cpu_byteenable = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    tick(2);
    chk("rst_MonDReg", MonDReg, 32'h0);
    chk("rst_wait", {31'd0, cpu_waitrequest}, 32'd1);
    reset = 1'b0;
    tick(1);

    // 1: load address, no read
    pulse_a(8'h10, 1'b0);
    tick(2);
    chk("t1_MonAReg", {24'd0, MonAReg}, 32'h10);
    chk("t1_ready", {31'd0, monitor_ready}, 32'd0);

    // 2: two back-to-back writes with auto-increment
    pulse_b(32'hDEADBEEF);
    pulse_b(32'hDEADBEEF);
    tick(3);
    chk("t2_MonAReg", {24'd0, MonAReg}, 32'h12);

    // 3: read with address load, result two clocks after the pulse
    pulse_a(8'h10, 1'b1);
    tick(1);
    chk("t3_ready_early", {31'd0, monitor_ready}, 32'd0);
    tick(1);
    chk("t3_MonDReg", MonDReg, 32'hDEADBEEF);
    chk("t3_ready", {31'd0, monitor_ready}, 32'd1);
    chk("t3_MonAReg", {24'd0, MonAReg}, 32'h10);
    pulse_n();
    tick(3);
    chk("t3_inc_MonAReg", {24'd0, MonAReg}, 32'h11);

    // 4: write at top address wraps the address register
    pulse_a(8'hFF, 1'b0);
    pulse_b(32'h12345678);
    tick(3);
    chk("t4_wrap", {24'd0, MonAReg}, 32'h00);
    cpu_rd(8'hFF, rd);
    chk("t4_ram_ff", rd, 32'h12345678);

    // 5: CPU read held while JTAG ops are pending; JTAG goes first
    pulse_a(8'h11, 1'b1);
    cpu_address = 8'h11; cpu_read = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_no_action_ocimem_a = 1'b0;
    chk("t5_cpu_stalled", {31'd0, cpu_waitrequest}, 32'd1);
    cpu_rd(8'h11, rd);
    chk("t5_cpu_data", rd, 32'hDEADBEEF);
    chk("t5_MonAReg", {24'd0, MonAReg}, 32'h12);
    chk("t5_MonDReg", MonDReg, 32'hDEADBEEF);

    // 6: byte-lane CPU write, then reset in the middle of a JTAG read
    cpu_wr(8'h20, 32'h12345678, 4'hF);
    cpu_wr(8'h20, 32'hAAAA5555, 4'b0011);
    cpu_rd(8'h20, rd);
    chk("t6_merge", rd, 32'h12345555);
    pulse_a(8'h20, 1'b1);
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("t6_rst_MonDReg", MonDReg, 32'h0);
    chk("t6_rst_MonAReg", {24'd0, MonAReg}, 32'h0);
    chk("t6_rst_ready", {31'd0, monitor_ready}, 32'd0);
    chk("t6_rst_rdata", cpu_readdata, 32'h0);
    reset = 1'b0;
    tick(2);
    cpu_rd(8'h20, rd);
    chk("t6_ram_kept", rd, 32'h12345555);

    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
